draw_circles_multi: RTL and testbench
=====================================

// Module: draw_circles_multi
// PURPOSE
// - Parametrised successor to the single-object circle drawer. Draws N_OBJ circles (players, ball, extras) in one pipeline stage group.
// - Per object: colour, radius, filled/outline mode and enable. Lowest index wins where objects overlap.
// - Sits after draw_playground in the 65 MHz VGA chain (1024x768). It replaces the cascaded per-object draw stages.
// - Also reports, once per frame, which objects overlapped on screen. draw_ball_ctl uses this as a hit indication.
// PARAMETERS
// - N_OBJ    3  number of circle objects (1..8)
// - RING_W   3  outline thickness in pixels for objects with mode=1
// - LATENCY  3  fixed pipeline depth in clk_in cycles. Informative; the implementation requires 3.
// PORTS
// - clk_in       in   1        pixel clock, 65 MHz
// - rst_n        in   1        asynchronous, active-low reset
// - hcount_in    in   12       horizontal pixel count
// - vcount_in    in   12       vertical line count
// - hsync_in     in   1        horizontal sync
// - vsync_in     in   1        vertical sync
// - hblnk_in     in   1        horizontal blanking
// - vblnk_in     in   1        vertical blanking
// - rgb_in       in   12       background pixel {r,g,b}
// - xpos_in      in   12*N_OBJ object centre x; object i at bits [12i+11:12i]
// - ypos_in      in   12*N_OBJ object centre y
// - radius_in    in   8*N_OBJ  object radius, 0..255
// - color_in     in   12*N_OBJ object colour
// - mode_in      in   N_OBJ    per object: 0 = filled, 1 = outline (ring of RING_W)
// - enable_in    in   N_OBJ    per object: 1 = draw
// - hcount_out   out  12       hcount_in delayed by 3 cycles
// - vcount_out   out  12       vcount_in delayed by 3 cycles
// - hsync_out    out  1        hsync_in delayed by 3 cycles
// - vsync_out    out  1        vsync_in delayed by 3 cycles
// - hblnk_out    out  1        hblnk_in delayed by 3 cycles
// - vblnk_out    out  1        vblnk_in delayed by 3 cycles
// - rgb_out      out  12       composited pixel
// - hit_out      out  N_OBJ    objects covering the current output pixel; aligned with rgb_out
// - collide_out  out  N_OBJ    per-frame overlap flags, updated at start of vblank
// BEHAVIOUR
// - Reset (rst_n=0, async): every output = 0, pipeline registers cleared, shadow enables = 0.
//   - No object is drawn until the first frame latch after reset. Background passes through after 3 cycles.
// - Frame latch: fires on a vblnk_in rising edge (vblnk_in=1 and the previous sample was 0).
//   - Copies xpos/ypos/radius/color/mode/enable into shadow registers.
//   - Input changes between latches are ignored: no tearing.
// - Stage 1: dx = |hcount_in - x_i|, dy = |vcount_in - y_i|, each 12-bit unsigned.
// - Stage 2: d2 = dx*dx + dy*dy (25-bit). r2 = r*r (16-bit).
//   - ri = r - RING_W, saturating at 0. ri2 = ri*ri.
// - Stage 3 coverage for object i:
//   - en_i && d2 <= r2, and
//   - if mode_i = 1: additionally d2 > ri2. When r <= RING_W the object draws filled.
//   - radius 0 covers only the centre pixel.
// - rgb_out:
//   - 12'h000 if delayed hblnk or vblnk = 1.
//   - else the colour of the lowest-index covering object.
//   - else the delayed rgb_in.
// - hit_out: the raw coverage vector. Forced to 0 during blanking.
// - Collision accumulator:
//   - acc[i] is set on any visible pixel where object i is covered and at least one other object is also covered.
//   - On a vblnk_in rising edge: collide_out <= acc and acc <= 0 in the same cycle.
//   - Coverage arriving in that same cycle goes to the new frame.
// - Centres may sit off-screen (x or y >= 1024/768). Only the visible part is drawn; no wrap-around.
// - A reset mid-frame blanks objects until the next latch. Sync outputs follow 3 cycles behind inputs after release.
// TESTING
// - Reset, then 1 frame, enable=0 -> rgb_out = rgb_in delayed 3 cycles exactly; hit_out=0; collide_out=0.
// - Obj0 x=100 y=100 r=20 color=F00 filled -> (100,120) red, (100,121) background; (114,114) red (d2=392<=400).
// - Obj0 same, mode=1 RING_W=3 -> (100,118) red, (100,116) background (d2=256 <= ri2=289).
// - Obj0 at (200,200) r=20 and obj2 at (210,200) r=10 -> (205,200) shows obj0 colour; next vblank collide_out=3'b101.
// - Change x0 from 100 to 300 mid-frame -> circle stays at 100 until the vblank latch; drawn at 300 from the next frame.
// - Obj at x=5 r=20; assert rst_n low mid-line -> left edge clipped, no wrap at x=1023; outputs 0 immediately, objects hidden until the next latch.

Source files
------------

// File: rtl/draw_circles_multi.sv
// Composites up to N_OBJ filled or outlined circles over the incoming VGA pixel stream
// through a fixed 3-stage pipeline, and flags per frame which objects overlapped.
module draw_circles_multi #(
   parameter int N_OBJ   = 3,
   parameter int RING_W  = 3,
   parameter int LATENCY = 3
) (
   input  logic                  clk_in,
   input  logic                  rst_n,
   input  logic [11:0]           hcount_in,
   input  logic [11:0]           vcount_in,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   input  logic                  hblnk_in,
   input  logic                  vblnk_in,
   input  logic [11:0]           rgb_in,
   input  logic [12*N_OBJ-1:0]   xpos_in,
   input  logic [12*N_OBJ-1:0]   ypos_in,
   input  logic [8*N_OBJ-1:0]    radius_in,
   input  logic [12*N_OBJ-1:0]   color_in,
   input  logic [N_OBJ-1:0]      mode_in,
   input  logic [N_OBJ-1:0]      enable_in,
   output logic [11:0]           hcount_out,
   output logic [11:0]           vcount_out,
   output logic                  hsync_out,
   output logic                  vsync_out,
   output logic                  hblnk_out,
   output logic                  vblnk_out,
   output logic [11:0]           rgb_out,
   output logic [N_OBJ-1:0]      hit_out,
   output logic [N_OBJ-1:0]      collide_out
);

   if (LATENCY != 3) begin : g_bad_latency
      $error("draw_circles_multi supports only LATENCY = 3");
   end

   localparam logic [7:0] RING_R = 8'(RING_W);

   function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   function automatic logic [23:0] sq12(input logic [11:0] a);
      return {12'd0, a} * {12'd0, a};
   endfunction

   function automatic logic [15:0] sq8(input logic [7:0] a);
      return {8'd0, a} * {8'd0, a};
   endfunction

   logic              vblnk_prev_r;
   logic              frame_latch_s;
   logic [11:0]       x_sh_r   [N_OBJ];
   logic [11:0]       y_sh_r   [N_OBJ];
   logic [7:0]        r_sh_r   [N_OBJ];
   logic [11:0]       col_sh_r [N_OBJ];
   logic [N_OBJ-1:0]  mode_sh_r;
   logic [N_OBJ-1:0]  en_sh_r;

   logic [11:0]       dx_r [N_OBJ];
   logic [11:0]       dy_r [N_OBJ];
   logic [11:0]       h1_r, v1_r, rgb1_r;
   logic [3:0]        ctl1_r;

   logic [24:0]       d2_r  [N_OBJ];
   logic [15:0]       r2_r  [N_OBJ];
   logic [15:0]       ri2_r [N_OBJ];
   logic [N_OBJ-1:0]  en2_r, ring2_r;
   logic [11:0]       h2_r, v2_r, rgb2_r;
   logic [3:0]        ctl2_r;

   logic [N_OBJ-1:0]  cov_s, contrib_s, acc_r;
   logic [11:0]       pix_s;
   logic              visible_s, multi_s;

   assign frame_latch_s = vblnk_in & ~vblnk_prev_r;

   // Shadow copy of object parameters, refreshed only on the vblank rising edge
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         vblnk_prev_r <= 1'b0;
         mode_sh_r    <= '0;
         en_sh_r      <= '0;
         for (int i = 0; i < N_OBJ; i++) begin
            x_sh_r[i]   <= 12'd0;
            y_sh_r[i]   <= 12'd0;
            r_sh_r[i]   <= 8'd0;
            col_sh_r[i] <= 12'd0;
         end
      end else begin
         vblnk_prev_r <= vblnk_in;
         if (frame_latch_s) begin
            mode_sh_r <= mode_in;
            en_sh_r   <= enable_in;
            for (int i = 0; i < N_OBJ; i++) begin
               x_sh_r[i]   <= xpos_in[12*i +: 12];
               y_sh_r[i]   <= ypos_in[12*i +: 12];
               r_sh_r[i]   <= radius_in[8*i +: 8];
               col_sh_r[i] <= color_in[12*i +: 12];
            end
         end
      end
   end

   // Stages 1 and 2: per-object distances, squared distance and radius limits
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         {h1_r, v1_r, rgb1_r, ctl1_r} <= '0;
         {h2_r, v2_r, rgb2_r, ctl2_r} <= '0;
         en2_r   <= '0;
         ring2_r <= '0;
         for (int i = 0; i < N_OBJ; i++) begin
            dx_r[i]  <= 12'd0;
            dy_r[i]  <= 12'd0;
            d2_r[i]  <= 25'd0;
            r2_r[i]  <= 16'd0;
            ri2_r[i] <= 16'd0;
         end
      end else begin
         h1_r   <= hcount_in;
         v1_r   <= vcount_in;
         rgb1_r <= rgb_in;
         ctl1_r <= {hsync_in, vsync_in, hblnk_in, vblnk_in};
         h2_r   <= h1_r;
         v2_r   <= v1_r;
         rgb2_r <= rgb1_r;
         ctl2_r <= ctl1_r;
         en2_r  <= en_sh_r;
         for (int i = 0; i < N_OBJ; i++) begin
            dx_r[i]    <= abs_diff(hcount_in, x_sh_r[i]);
            dy_r[i]    <= abs_diff(vcount_in, y_sh_r[i]);
            d2_r[i]    <= 25'(sq12(dx_r[i])) + 25'(sq12(dy_r[i]));
            r2_r[i]    <= sq8(r_sh_r[i]);
            ri2_r[i]   <= (r_sh_r[i] > RING_R) ? sq8(r_sh_r[i] - RING_R) : 16'd0;
            // A ring thinner than its own radius degenerates to a filled disc
            ring2_r[i] <= mode_sh_r[i] && (r_sh_r[i] > RING_R);
         end
      end
   end

   // Stage 3 coverage per object
   always_comb begin
      cov_s = '0;
      for (int i = 0; i < N_OBJ; i++) begin
         cov_s[i] = en2_r[i] && (d2_r[i] <= {9'd0, r2_r[i]}) &&
                    (!ring2_r[i] || (d2_r[i] > {9'd0, ri2_r[i]}));
      end
   end

   // Priority mux: lowest index applied last so it wins
   always_comb begin
      pix_s = rgb2_r;
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         pix_s = cov_s[i] ? col_sh_r[i] : pix_s;
      end
   end

   assign visible_s = ~(ctl2_r[1] | ctl2_r[0]);
   assign multi_s   = |(cov_s & (cov_s - N_OBJ'(1)));
   assign contrib_s = (visible_s && multi_s) ? cov_s : '0;

   // Registered outputs and per-frame collision accumulation
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         hcount_out  <= 12'd0;
         vcount_out  <= 12'd0;
         {hsync_out, vsync_out, hblnk_out, vblnk_out} <= 4'd0;
         rgb_out     <= 12'd0;
         hit_out     <= '0;
         collide_out <= '0;
         acc_r       <= '0;
      end else begin
         hcount_out <= h2_r;
         vcount_out <= v2_r;
         {hsync_out, vsync_out, hblnk_out, vblnk_out} <= ctl2_r;
         rgb_out    <= visible_s ? pix_s : 12'h000;
         hit_out    <= visible_s ? cov_s : '0;
         if (frame_latch_s) begin
            collide_out <= acc_r;
            acc_r       <= contrib_s;
         end else begin
            acc_r       <= acc_r | contrib_s;
         end
      end
   end

endmodule

// File: tb/tb_draw_circles_multi.sv
// Directed bench for draw_circles_multi: passthrough, fill/ring geometry, priority,
// collision flags, frame-latched parameters, edge clipping and mid-frame reset.
module tb_draw_circles_multi;
   localparam int N = 3;

   logic clk_in = 1'b0;
   logic rst_n;
   logic [11:0] hcount_in, vcount_in, rgb_in;
   logic hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [12*N-1:0] xpos_in, ypos_in, color_in;
   logic [8*N-1:0] radius_in;
   logic [N-1:0] mode_in, enable_in;
   logic [11:0] hcount_out, vcount_out, rgb_out;
   logic hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [N-1:0] hit_out, collide_out;

   int checks = 0;
   int errors = 0;

   localparam logic [11:0] BG = 12'h0AB;

   draw_circles_multi #(.N_OBJ(N), .RING_W(3), .LATENCY(3)) dut (
      .clk_in(clk_in), .rst_n(rst_n),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
      .xpos_in(xpos_in), .ypos_in(ypos_in), .radius_in(radius_in),
      .color_in(color_in), .mode_in(mode_in), .enable_in(enable_in),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out),
      .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out), .hit_out(hit_out), .collide_out(collide_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_obj(input int idx, input logic [11:0] x, input logic [11:0] y,
                          input logic [7:0] r, input logic [11:0] col,
                          input logic md, input logic en);
      xpos_in[12*idx +: 12]  = x;
      ypos_in[12*idx +: 12]  = y;
      radius_in[8*idx +: 8]  = r;
      color_in[12*idx +: 12] = col;
      mode_in[idx]           = md;
      enable_in[idx]         = en;
   endtask

   task automatic frame_latch();
      hblnk_in = 1'b1; vblnk_in = 1'b0;
      repeat (4) step();
      vblnk_in = 1'b1;
      step();
      repeat (3) step();
      vblnk_in = 1'b0; hblnk_in = 1'b0;
      step();
   endtask

   task automatic probe(input logic [11:0] h, input logic [11:0] v,
                        output logic [11:0] rgb, output logic [N-1:0] hit);
      hcount_in = h; vcount_in = v; rgb_in = BG;
      hblnk_in = 1'b0; vblnk_in = 1'b0;
      repeat (3) step();
      rgb = rgb_out;
      hit = hit_out;
   endtask

   task automatic expect_pix(input string name, input logic [11:0] h, input logic [11:0] v,
                             input logic [11:0] exp_rgb, input logic [N-1:0] exp_hit);
      logic [11:0] rgb;
      logic [N-1:0] hit;
      probe(h, v, rgb, hit);
      checks++;
      if (rgb !== exp_rgb || hit !== exp_hit) begin
         errors++;
         $display("FAIL %s (%0d,%0d): got rgb=%h hit=%b, expected rgb=%h hit=%b",
                  name, h, v, rgb, hit, exp_rgb, exp_hit);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      hcount_in = 12'd55; vcount_in = 12'd66; rgb_in = 12'hFFF;
      hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
      xpos_in = '0; ypos_in = '0; radius_in = '0; color_in = '0;
      mode_in = '0; enable_in = '0;
      repeat (3) step();
      checks++;
      if ({hcount_out, vcount_out, rgb_out, hsync_out, vsync_out, hit_out, collide_out} !== '0) begin
         errors++;
         $display("FAIL reset: got h=%0d v=%0d rgb=%h hs=%b vs=%b hit=%b col=%b, expected all 0",
                  hcount_out, vcount_out, rgb_out, hsync_out, vsync_out, hit_out, collide_out);
      end
      rst_n = 1'b1;
      hsync_in = 1'b0; vsync_in = 1'b0;
      step();
   endtask

   task automatic test_passthrough();
      logic [11:0] hv [10];
      logic [11:0] cv [10];
      logic        hb [10];
      logic        hs [10];
      frame_latch();
      for (int i = 0; i < 10; i++) begin
         hv[i] = 12'(300 + i * 7);
         cv[i] = 12'(i * 12'h123);
         hb[i] = (i == 4 || i == 5);
         hs[i] = (i % 3 == 0);
      end
      for (int j = 0; j < 10; j++) begin
         hcount_in = hv[j]; vcount_in = 12'd40; rgb_in = cv[j];
         hblnk_in = hb[j]; hsync_in = hs[j]; vblnk_in = 1'b0;
         step();
         if (j >= 2) begin
            checks++;
            if (hcount_out !== hv[j-2] || hsync_out !== hs[j-2] || hblnk_out !== hb[j-2] ||
                rgb_out !== (hb[j-2] ? 12'h000 : cv[j-2]) || hit_out !== 3'b000) begin
               errors++;
               $display("FAIL passthrough[%0d]: got h=%0d hs=%b hb=%b rgb=%h hit=%b, expected h=%0d hs=%b hb=%b rgb=%h hit=000",
                        j - 2, hcount_out, hsync_out, hblnk_out, rgb_out, hit_out,
                        hv[j-2], hs[j-2], hb[j-2], hb[j-2] ? 12'h000 : cv[j-2]);
            end
         end
      end
      hsync_in = 1'b0;
      checks++;
      if (collide_out !== 3'b000) begin
         errors++;
         $display("FAIL passthrough_collide: got %b, expected 000", collide_out);
      end
   endtask

   task automatic test_filled();
      set_obj(0, 12'd100, 12'd100, 8'd20, 12'hF00, 1'b0, 1'b1);
      frame_latch();
      expect_pix("filled_edge", 12'd100, 12'd120, 12'hF00, 3'b001);
      expect_pix("filled_out", 12'd100, 12'd121, BG, 3'b000);
      expect_pix("filled_diag", 12'd114, 12'd114, 12'hF00, 3'b001);
   endtask

   task automatic test_ring();
      set_obj(0, 12'd100, 12'd100, 8'd20, 12'hF00, 1'b1, 1'b1);
      frame_latch();
      expect_pix("ring_in", 12'd100, 12'd118, 12'hF00, 3'b001);
      expect_pix("ring_hole", 12'd100, 12'd116, BG, 3'b000);
      expect_pix("ring_centre", 12'd100, 12'd100, BG, 3'b000);
      set_obj(0, 12'd100, 12'd100, 8'd2, 12'hF00, 1'b1, 1'b1);
      frame_latch();
      expect_pix("thin_ring_filled", 12'd100, 12'd100, 12'hF00, 3'b001);
      set_obj(0, 12'd100, 12'd100, 8'd0, 12'hF00, 1'b0, 1'b1);
      frame_latch();
      expect_pix("r0_centre", 12'd100, 12'd100, 12'hF00, 3'b001);
      expect_pix("r0_next", 12'd101, 12'd100, BG, 3'b000);
   endtask

   task automatic test_overlap();
      set_obj(0, 12'd200, 12'd200, 8'd20, 12'h0F0, 1'b0, 1'b1);
      set_obj(1, 12'd0, 12'd0, 8'd50, 12'hFFF, 1'b0, 1'b0);
      set_obj(2, 12'd210, 12'd200, 8'd10, 12'h00F, 1'b0, 1'b1);
      frame_latch();
      checks++;
      if (collide_out !== 3'b000) begin
         errors++;
         $display("FAIL collide_prev: got %b, expected 000", collide_out);
      end
      expect_pix("overlap_prio", 12'd205, 12'd200, 12'h0F0, 3'b101);
      expect_pix("overlap_single", 12'd185, 12'd200, 12'h0F0, 3'b001);
      frame_latch();
      checks++;
      if (collide_out !== 3'b101) begin
         errors++;
         $display("FAIL collide_flags: got %b, expected 101", collide_out);
      end
      frame_latch();
      checks++;
      if (collide_out !== 3'b000) begin
         errors++;
         $display("FAIL collide_clear: got %b, expected 000", collide_out);
      end
      set_obj(2, 12'd210, 12'd200, 8'd10, 12'h00F, 1'b0, 1'b0);
   endtask

   task automatic test_no_tearing();
      set_obj(0, 12'd100, 12'd100, 8'd20, 12'hF00, 1'b0, 1'b1);
      frame_latch();
      set_obj(0, 12'd300, 12'd100, 8'd20, 12'hF00, 1'b0, 1'b1);
      expect_pix("tear_old_pos", 12'd100, 12'd100, 12'hF00, 3'b001);
      expect_pix("tear_new_hidden", 12'd300, 12'd100, BG, 3'b000);
      frame_latch();
      expect_pix("tear_new_pos", 12'd300, 12'd100, 12'hF00, 3'b001);
      expect_pix("tear_old_gone", 12'd100, 12'd100, BG, 3'b000);
   endtask

   task automatic test_edge_and_reset();
      set_obj(0, 12'd5, 12'd100, 8'd20, 12'hF00, 1'b0, 1'b1);
      set_obj(1, 12'd1030, 12'd300, 8'd20, 12'h0F0, 1'b0, 1'b1);
      frame_latch();
      expect_pix("clip_left", 12'd0, 12'd100, 12'hF00, 3'b001);
      expect_pix("no_wrap", 12'd1023, 12'd100, BG, 3'b000);
      expect_pix("offscreen_centre", 12'd1015, 12'd300, 12'h0F0, 3'b010);
      hcount_in = 12'd5; vcount_in = 12'd100;
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (rgb_out !== 12'h000 || hit_out !== 3'b000 || hcount_out !== 12'd0) begin
         errors++;
         $display("FAIL async_reset: got rgb=%h hit=%b h=%0d, expected 000/000/0",
                  rgb_out, hit_out, hcount_out);
      end
      step();
      rst_n = 1'b1;
      expect_pix("hidden_after_reset", 12'd5, 12'd100, BG, 3'b000);
      frame_latch();
      expect_pix("shown_after_latch", 12'd5, 12'd100, 12'hF00, 3'b001);
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_filled();
      test_ring();
      test_overlap();
      test_no_tearing();
      test_edge_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
